// File: rtl/mvm_ctrl_pkg.sv
// Shared types and sizing helpers for the mvm job sequencer.
package mvm_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitD,
        StLdm,
        StLdv,
        StWout,
        StRun,
        StCap
    } state_t;

    localparam int unsigned MVM_K = 3;

    function automatic int unsigned mat_words(input int unsigned k);
        return k * k;
    endfunction

    function automatic int unsigned job_words(input int unsigned k);
        return k * k + k;
    endfunction

    localparam int unsigned MAT_WORDS = mat_words(MVM_K);
    localparam int unsigned JOB_WORDS = job_words(MVM_K);

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; read data reads as zero when empty.
module sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LastIdx) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LastIdx) ? '0 : r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/mvm_job_ctrl.sv
// Job sequencer: buffers operands, replays them to the mvm engine and collects K results.
module mvm_job_ctrl
    import mvm_ctrl_pkg::*;
#(
    parameter int unsigned K       = MVM_K,
    parameter int unsigned B       = 8,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_cmd_valid,
    output logic           o_cmd_ready,
    input  logic           i_cmd_reuse,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    input  logic [B-1:0]   i_in_data,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [2*B-1:0] o_out_data,
    output logic           o_busy,
    output logic           o_err,
    output logic           o_mvm_reset,
    output logic           o_mvm_start_matrix,
    output logic           o_mvm_start_vector,
    output logic           o_mvm_start,
    output logic [B-1:0]   o_mvm_data_in,
    input  logic           i_mvm_done,
    input  logic [2*B-1:0] i_mvm_data_out
);
    localparam int unsigned MatWords = mat_words(K);
    localparam int unsigned JobWords = job_words(K);
    localparam int unsigned ICW      = $clog2(JobWords + 1);
    localparam int unsigned OCW      = $clog2(K + 1);
    localparam int unsigned BW       = $clog2(MatWords + 1);
    localparam int unsigned WW       = $clog2(TIMEOUT + 1);

    state_t         r_state, w_state_d;
    logic [BW-1:0]  r_beat, w_beat_d;
    logic [WW-1:0]  r_wd, w_wd_d;
    logic [ICW-1:0] r_need, w_need_d;
    logic           r_reuse, w_reuse_d;
    logic           r_mat_valid, w_mat_valid_d;
    logic           r_err, w_err_d;
    logic [1:0]     r_mrst_cnt, w_mrst_cnt_d;
    logic           r_cmd_ready;
    logic           r_sm, w_sm_d;
    logic           r_sv, w_sv_d;
    logic           r_st, w_st_d;
    logic [B-1:0]   r_data_in, w_data_in_d;

    logic           w_in_pop;
    logic [B-1:0]   w_in_rdata;
    logic [ICW-1:0] w_in_count;
    logic           w_in_full;
    logic           w_in_empty;
    logic           w_out_push;
    logic [OCW-1:0] w_out_count;
    logic           w_out_full;
    logic           w_out_empty;

    sync_fifo #(.W(B), .DEPTH(JobWords)) u_in_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_in_valid),
        .i_wdata (i_in_data),
        .i_pop   (w_in_pop),
        .o_rdata (w_in_rdata),
        .o_count (w_in_count),
        .o_full  (w_in_full),
        .o_empty (w_in_empty)
    );

    sync_fifo #(.W(2 * B), .DEPTH(K)) u_out_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_out_push),
        .i_wdata (i_mvm_data_out),
        .i_pop   (i_out_ready),
        .o_rdata (o_out_data),
        .o_count (w_out_count),
        .o_full  (w_out_full),
        .o_empty (w_out_empty)
    );

    assign o_in_ready         = !w_in_full;
    assign o_cmd_ready        = r_cmd_ready;
    assign o_out_valid        = !w_out_empty;
    assign o_busy             = (r_state != StIdle);
    assign o_err              = r_err;
    assign o_mvm_reset        = (r_mrst_cnt != 2'd0);
    assign o_mvm_start_matrix = r_sm;
    assign o_mvm_start_vector = r_sv;
    assign o_mvm_start        = r_st;
    assign o_mvm_data_in      = r_data_in;

    // Pulses and engine data are registered, so each decision lands one cycle after its state.
    always_comb begin
        w_state_d     = r_state;
        w_beat_d      = r_beat;
        w_wd_d        = r_wd;
        w_need_d      = r_need;
        w_reuse_d     = r_reuse;
        w_mat_valid_d = r_mat_valid;
        w_err_d       = r_err;
        w_mrst_cnt_d  = (r_mrst_cnt != 2'd0) ? r_mrst_cnt - 2'd1 : 2'd0;
        w_sm_d        = 1'b0;
        w_sv_d        = 1'b0;
        w_st_d        = 1'b0;
        w_data_in_d   = '0;
        w_in_pop      = 1'b0;
        w_out_push    = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_cmd_valid && r_cmd_ready) begin
                    w_reuse_d = i_cmd_reuse;
                    w_need_d  = i_cmd_reuse ? ICW'(K) : ICW'(JobWords);
                    if (i_cmd_reuse && !r_mat_valid) begin
                        w_err_d = 1'b1;
                    end
                    w_state_d = StWaitD;
                end
            end
            StWaitD: begin
                if (w_in_count >= r_need) begin
                    w_beat_d = '0;
                    if (r_reuse) begin
                        w_sv_d    = 1'b1;
                        w_state_d = StLdv;
                    end else begin
                        w_sm_d    = 1'b1;
                        w_state_d = StLdm;
                    end
                end
            end
            StLdm: begin
                if (r_beat < BW'(MatWords)) begin
                    w_in_pop    = !w_in_empty;
                    w_data_in_d = w_in_rdata;
                    w_beat_d    = r_beat + 1'b1;
                end else begin
                    w_sv_d        = 1'b1;
                    w_mat_valid_d = 1'b1;
                    w_beat_d      = '0;
                    w_state_d     = StLdv;
                end
            end
            StLdv: begin
                w_in_pop    = !w_in_empty;
                w_data_in_d = w_in_rdata;
                w_beat_d    = r_beat + 1'b1;
                if (r_beat == BW'(K - 1)) begin
                    w_state_d = StWout;
                end
            end
            StWout: begin
                if (w_out_count == '0) begin
                    w_st_d    = 1'b1;
                    w_wd_d    = '0;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (i_mvm_done) begin
                    w_beat_d  = '0;
                    w_state_d = StCap;
                end else if (r_wd == WW'(TIMEOUT)) begin
                    w_err_d       = 1'b1;
                    w_mrst_cnt_d  = 2'd2;
                    w_mat_valid_d = 1'b0;
                    w_state_d     = StIdle;
                end else begin
                    w_wd_d = r_wd + 1'b1;
                end
            end
            StCap: begin
                w_out_push = !w_out_full;
                w_beat_d   = r_beat + 1'b1;
                if (r_beat == BW'(K - 1)) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_beat      <= '0;
            r_wd        <= '0;
            r_need      <= '0;
            r_reuse     <= 1'b0;
            r_mat_valid <= 1'b0;
            r_err       <= 1'b0;
            r_mrst_cnt  <= 2'd2;
            r_cmd_ready <= 1'b0;
            r_sm        <= 1'b0;
            r_sv        <= 1'b0;
            r_st        <= 1'b0;
            r_data_in   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_beat      <= w_beat_d;
            r_wd        <= w_wd_d;
            r_need      <= w_need_d;
            r_reuse     <= w_reuse_d;
            r_mat_valid <= w_mat_valid_d;
            r_err       <= w_err_d;
            r_mrst_cnt  <= w_mrst_cnt_d;
            r_cmd_ready <= (w_state_d == StIdle);
            r_sm        <= w_sm_d;
            r_sv        <= w_sv_d;
            r_st        <= w_st_d;
            r_data_in   <= w_data_in_d;
        end
    end

endmodule
